ecp5_pll_dyn_ctrl: RTL and testbench

- Runtime controller for an ECP5 EHXPLLL instance, clocked from the PLL reference clock (25 MHz on ULX3S).
- Sequences PLL reset and lock qualification, then generates a system reset release.
- Accepts dynamic phase-shift requests (channel, direction, step count) and drives the PLL PHASESEL, PHASEDIR and PHASESTEP pins with correctly timed pulses.
- Sits between the board top level and the PLL wrapper. It replaces the tied-off phase pins and the raw LOCK use.

---
 rtl/ecp5_pll_pkg.sv | 26 ++
 rtl/ecp5_pll_dyn_ctrl_lock_filter.sv | 50 +++++
 rtl/ecp5_pll_dyn_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ecp5_pll_dyn_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecp5_pll_pkg.sv
// rtl/ecp5_pll_pkg.sv - shared encodings and FSM state type for the ECP5 PLL controller
// Purpose: channel/direction encodings for PHASESEL/PHASEDIR and the controller state enum.
// Ports: none (package).
package ecp5_pll_pkg;

  // PHASESEL[1:0] channel encodings
  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;
  localparam logic [1:0] SEL_CLKOP  = 2'b11;

  // PHASEDIR encodings
  localparam logic DIR_LAG  = 1'b0;
  localparam logic DIR_LEAD = 1'b1;

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    IDLE,
    SETUP,
    STEP_LO,
    STEP_HI,
    DONE
  } pll_state_e;

endpackage

// File: rtl/ecp5_pll_dyn_ctrl_lock_filter.sv
// rtl/ecp5_pll_dyn_ctrl_lock_filter.sv - LOCK synchroniser and stability filter
// Purpose: brings the raw PLL LOCK into the reference clock domain and qualifies it.
// Ports:
//   clock   in  reference clock
//   reset   in  asynchronous active-high reset
//   clr     in  clears the filter counter (held while the PLL is in reset)
//   lock_in in  raw LOCK, asynchronous to clock
//   lock_ok out high while LOCK has been stably high for LOCK_FILTER cycles
module pll_lock_filter #(
  parameter int LOCK_FILTER = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic lock_in,
  output logic lock_ok
);

  localparam int CW = $clog2(LOCK_FILTER + 1);
  localparam logic [CW-1:0] LIM = CW'(LOCK_FILTER);

  logic          lk_m;
  logic          lk_s;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      lk_m <= lock_in;
      lk_s <= lk_m;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || !lk_s) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Gating with lk_s makes lock_ok fall in the same cycle lk_s falls, so the
  // controller sees a loss of lock without waiting for the counter to clear.
  assign lock_ok = lk_s && (cnt == LIM);

endmodule

// File: rtl/ecp5_pll_dyn_ctrl.sv
// rtl/ecp5_pll_dyn_ctrl.sv - ECP5 EHXPLLL runtime reset/lock and dynamic phase-shift controller
// Purpose: sequences PLL reset and lock qualification, releases the system reset, and
//   turns phase-shift requests into timed PHASESEL/PHASEDIR/PHASESTEP activity.
// Optional: define ECP5_PLL_PHASE_TRACK_EN to add per-channel phase accumulators (phase_acc).
// Ports:
//   clock, reset            reference clock, asynchronous active-high reset
//   pll_locked              raw EHXPLLL LOCK
//   pll_rst                 EHXPLLL RST
//   pll_phasesel/phasedir   PHASESEL[1:0] / PHASEDIR, held from the last accepted request
//   pll_phasestep           PHASESTEP, idle high, active-low pulses
//   rst_out                 system reset, high until lock is stable
//   req_valid/req_ready     request handshake; req_sel, req_dir, req_steps request fields
//   done                    one-cycle pulse on request completion
//   lock_lost               one-cycle pulse on detected loss of lock
//   phase_acc               4 x PHASE_W signed accumulators (optional feature)
module ecp5_pll_dyn_ctrl
  import ecp5_pll_pkg::*;
#(
  parameter int LOCK_FILTER = 1024,
  parameter int RST_HOLD    = 16,
  parameter int SETUP_CYC   = 4,
  parameter int PULSE_CYC   = 4,
  parameter int STEP_W      = 6,
  parameter int PHASE_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic [1:0]        pll_phasesel,
  output logic              pll_phasedir,
  output logic              pll_phasestep,
  output logic              rst_out,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  output logic              done,
`ifdef ECP5_PLL_PHASE_TRACK_EN
  output logic [4*PHASE_W-1:0] phase_acc,
`endif
  output logic              lock_lost
);

  localparam int MAXC  = (RST_HOLD > SETUP_CYC) ?
                         ((RST_HOLD > PULSE_CYC) ? RST_HOLD : PULSE_CYC) :
                         ((SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC);
  localparam int CNT_W = $clog2(MAXC + 1);

  pll_state_e        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [STEP_W-1:0] rem;
  logic [1:0]        sel_q;
  logic              dir_q;
  logic              lock_ok;
  logic              accept, step_done, loss;

  pll_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock (
    .clock   (clock),
    .reset   (reset),
    .clr     (state == RST_PLL),
    .lock_in (pll_locked),
    .lock_ok (lock_ok)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RST_PLL;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + 1'b1;
    accept    = 1'b0;
    step_done = 1'b0;
    loss      = 1'b0;
    case (state)
      RST_PLL: begin
        if (cnt == CNT_W'(RST_HOLD - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_ok) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (req_steps == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          state_d = STEP_LO;
          cnt_d   = '0;
        end
      end
      STEP_LO: begin
        if (cnt == CNT_W'(PULSE_CYC - 1)) begin
          state_d = STEP_HI;
          cnt_d   = '0;
        end
      end
      STEP_HI: begin
        if (cnt == CNT_W'(PULSE_CYC - 1)) begin
          step_done = 1'b1;
          cnt_d     = '0;
          state_d   = (rem == STEP_W'(1)) ? DONE : STEP_LO;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RST_PLL;
      end
    endcase
    // Loss of lock overrides everything once the PLL has been qualified.
    if (state != RST_PLL && state != WAIT_LOCK && !lock_ok) begin
      loss      = 1'b1;
      accept    = 1'b0;
      step_done = 1'b0;
      state_d   = RST_PLL;
      cnt_d     = '0;
    end
  end

  // PLL pins are registered from the next state so they change cleanly on the
  // clock edge that enters each state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pll_rst       <= 1'b1;
      pll_phasestep <= 1'b1;
      rst_out       <= 1'b1;
      lock_lost     <= 1'b0;
      sel_q         <= SEL_CLKOS;
      dir_q         <= DIR_LAG;
      rem           <= '0;
    end else begin
      pll_rst       <= (state_d == RST_PLL);
      pll_phasestep <= (state_d != STEP_LO);
      rst_out       <= (state == RST_PLL) || (state == WAIT_LOCK);
      lock_lost     <= loss;
      if (accept) begin
        sel_q <= req_sel;
        dir_q <= req_dir;
        rem   <= req_steps;
      end else if (step_done) begin
        rem <= rem - 1'b1;
      end
    end
  end

  assign pll_phasesel = sel_q;
  assign pll_phasedir = dir_q;
  assign req_ready    = (state == IDLE) && lock_ok;
  assign done         = (state == DONE) && lock_ok;

`ifdef ECP5_PLL_PHASE_TRACK_EN
  logic [PHASE_W-1:0] acc [4];

  // Cleared on the edge that enters RST_PLL: resetting the PLL restores static phases.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) acc[k] <= '0;
    end else if (state_d == RST_PLL) begin
      for (int k = 0; k < 4; k++) acc[k] <= '0;
    end else if (step_done) begin
      acc[sel_q] <= (dir_q == DIR_LEAD) ? acc[sel_q] + 1'b1 : acc[sel_q] - 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_acc
    assign phase_acc[g*PHASE_W +: PHASE_W] = acc[g];
  end
`endif

endmodule

// File: tb/tb_ecp5_pll_dyn_ctrl.sv
// tb/tb_ecp5_pll_dyn_ctrl.sv - scoreboard testbench for ecp5_pll_dyn_ctrl
module tb_ecp5_pll_dyn_ctrl;

  localparam int LF = 8, RH = 4, SC = 4, PC = 4, SW = 9, PW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pll_locked = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_sel = 2'b00;
  logic          req_dir = 1'b0;
  logic [SW-1:0] req_steps = '0;
  logic          pll_rst, pll_phasedir, pll_phasestep, rst_out, req_ready, done, lock_lost;
  logic [1:0]    pll_phasesel;
`ifdef ECP5_PLL_PHASE_TRACK_EN
  logic [4*PW-1:0] phase_acc;
`endif

  ecp5_pll_dyn_ctrl #(
    .LOCK_FILTER(LF), .RST_HOLD(RH), .SETUP_CYC(SC), .PULSE_CYC(PC),
    .STEP_W(SW), .PHASE_W(PW)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
    .pll_phasestep(pll_phasestep), .rst_out(rst_out), .req_valid(req_valid),
    .req_ready(req_ready), .req_sel(req_sel), .req_dir(req_dir),
    .req_steps(req_steps), .done(done),
`ifdef ECP5_PLL_PHASE_TRACK_EN
    .phase_acc(phase_acc),
`endif
    .lock_lost(lock_lost)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_loss;
    int          at;
    int          pulses;
    logic [1:0]  sel;
    logic        dir;
    logic [31:0] acc;
  } exp_t;

  exp_t q[$];
  logic [7:0] macc [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

  function automatic logic [31:0] packed_acc();
    return {macc[3], macc[2], macc[1], macc[0]};
  endfunction

  // Monitor: counts PHASESTEP pulses and checks each response against the scoreboard.
  logic prev_ps = 1'b1;
  int   lowlen = 0;
  int   pulses = 0;
  exp_t mon_e;

  always @(negedge clock) begin
    if (!reset) begin
      if (prev_ps && !pll_phasestep) begin
        pulses++;
        lowlen = 1;
      end else if (!pll_phasestep) begin
        lowlen++;
      end else if (!prev_ps && !lock_lost) begin
        check("pulse_width", 64'(lowlen), 64'(PC));
      end
      prev_ps = pll_phasestep;
      if (done || lock_lost) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: done=%0b lock_lost=%0b with empty scoreboard (cycle %0d)",
                   done, lock_lost, cyc);
        end else begin
          mon_e = q.pop_front();
          check("event_kind", 64'(lock_lost), 64'(mon_e.is_loss));
          check("event_cycle", 64'(cyc), 64'(mon_e.at));
          check("pulse_count", 64'(pulses), 64'(mon_e.pulses));
          if (mon_e.is_loss) begin
            check("step_high_on_loss", 64'(pll_phasestep), 64'd1);
          end else begin
            check("phasesel", 64'(pll_phasesel), 64'(mon_e.sel));
            check("phasedir", 64'(pll_phasedir), 64'(mon_e.dir));
          end
`ifdef ECP5_PLL_PHASE_TRACK_EN
          check("phase_acc", 64'(phase_acc), 64'(mon_e.acc));
`endif
        end
        pulses = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept cycle.
  task automatic send(input logic [1:0] s, input logic d, input int n,
                      input bit expect_done, output int acc_cyc);
    exp_t e;
    req_sel   = s;
    req_dir   = d;
    req_steps = SW'(n);
    req_valid = 1'b1;
    acc_cyc   = -1;
    for (int t = 0; t < 5000; t++) begin
      if (req_ready) begin
        acc_cyc = cyc;
        break;
      end
      @(negedge clock);
    end
    if (acc_cyc < 0) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else if (expect_done) begin
      macc[s] = d ? macc[s] + 8'(n) : macc[s] - 8'(n);
      e.is_loss = 1'b0;
      e.at      = acc_cyc + ((n == 0) ? 1 : SC + 2 * PC * n + 1);
      e.pulses  = n;
      e.sel     = s;
      e.dir     = d;
      e.acc     = packed_acc();
      q.push_back(e);
    end
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int t = 0; t < budget; t++) begin
      if (q.size() == 0) break;
      @(negedge clock);
    end
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    @(negedge clock);
  endtask

  task automatic wait_ready(input int budget, output int at);
    at = -1;
    for (int t = 0; t < budget; t++) begin
      if (req_ready) begin
        at = cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic count_rst_high(output int hi);
    hi = 0;
    for (int t = 0; t < 50; t++) begin
      if (!pll_rst) break;
      hi++;
      @(negedge clock);
    end
  endtask

  initial begin : stim
    int r0, hi, t_rdy, a1, a2, a3, a4, l0;
    exp_t e;

    repeat (3) @(negedge clock);
    check("rst_pll_rst", 64'(pll_rst), 64'd1);
    check("rst_rst_out", 64'(rst_out), 64'd1);
    check("rst_phasestep", 64'(pll_phasestep), 64'd1);
    check("rst_phasesel", 64'(pll_phasesel), 64'd0);
    check("rst_phasedir", 64'(pll_phasedir), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lock_lost", 64'(lock_lost), 64'd0);

    // Power-up: PLL reset hold, then lock qualification.
    reset = 1'b0;
    r0 = cyc;
    count_rst_high(hi);
    check("pll_rst_hold_powerup", 64'(hi), 64'(RH));
    while (cyc < r0 + 10) @(negedge clock);
    pll_locked = 1'b1;
    wait_ready(100, t_rdy);
    check("lock_ready_cycle", 64'(t_rdy - r0), 64'd21);
    check("rst_out_at_idle_entry", 64'(rst_out), 64'd1);
    @(negedge clock);
    check("rst_out_released", 64'(rst_out), 64'd0);

    // Three lead steps on CLKOS2, then a held request that must wait for IDLE.
    send(2'b01, 1'b1, 3, 1'b1, a1);
    send(2'b10, 1'b1, 0, 1'b1, a2);
    check("held_req_accept_cycle", 64'(a2), 64'(a1 + SC + 2 * PC * 3 + 2));
    drain(200);

    // Loss of lock during the second low pulse.
    send(2'b00, 1'b0, 3, 1'b0, a3);
    while (cyc < a3 + 1 + SC + 2 * PC) @(negedge clock);
    check("in_second_step_lo", 64'(pll_phasestep), 64'd0);
    pll_locked = 1'b0;
    l0 = cyc;
    for (int k = 0; k < 4; k++) macc[k] = 8'h00;
    e.is_loss = 1'b1;
    e.at      = l0 + 3;
    e.pulses  = 2;
    e.sel     = 2'b00;
    e.dir     = 1'b0;
    e.acc     = packed_acc();
    q.push_back(e);
    while (cyc < l0 + 3) @(negedge clock);
    count_rst_high(hi);
    check("pll_rst_hold_relock", 64'(hi), 64'(RH));
    check("rst_out_after_loss", 64'(rst_out), 64'd1);
    check("req_ready_after_loss", 64'(req_ready), 64'd0);
    drain(10);
    l0 = cyc;
    pll_locked = 1'b1;
    wait_ready(100, t_rdy);
    check("relock_ready_cycle", 64'(t_rdy - l0), 64'd11);
    @(negedge clock);
    check("rst_out_rereleased", 64'(rst_out), 64'd0);

    // CLKOP lagged by 2^PHASE_W + 1 steps: accumulator wraps to -1.
    send(2'b11, 1'b0, 257, 1'b1, a4);
    drain(3000);
`ifdef ECP5_PLL_PHASE_TRACK_EN
    check("wrap_ch3", 64'(phase_acc[3*PW +: PW]), 64'hFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    repeat (20000) @(posedge clock);
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: test did not complete within 20000 cycles");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
